bp_me_wormhole_packet_deserializer: RTL and testbench
=====================================================

BP_ME_WORMHOLE_PACKET_DESERIALIZER -- requirements
Module: bp_me_wormhole_packet_deserializer

Interface
REQ-001 Parameter flit_width_p, default 16: router flit width in bits.
REQ-002 Parameter x_cord_width_p, default 2: X coordinate field width.
REQ-003 Parameter y_cord_width_p, default 2: Y coordinate field width.
REQ-004 Parameter len_width_p, default 2: length field width; len = number of body flits after the header flit.
REQ-005 Parameter max_num_flit_p, default 3: maximum flits per packet, header included.
REQ-006 Parameter max_payload_width_p, default 40: payload width in bits.
REQ-007 Packet layout, LSB first, SHALL be x cord, y cord, len, payload. Payload offset = x_cord_width_p + y_cord_width_p + len_width_p.
REQ-008 One clock; reset is synchronous and active-low.
REQ-009 clk_i  in  1  clock; all state updates on the rising edge.
REQ-010 reset_i  in  1  synchronous active-low reset; low at a rising edge resets the block.
REQ-011 data_i  in  flit_width_p  flit from the router.
REQ-012 v_i  in  1  flit valid.
REQ-013 ready_o  out  1  flit accepted when v_i & ready_o.
REQ-014 data_o  out  max_payload_width_p  reassembled payload.
REQ-015 x_o / y_o  out  x_cord_width_p / y_cord_width_p  header destination coordinates of the held packet.
REQ-016 v_o  out  1  packet valid.
REQ-017 ready_i  in  1  packet consumed when v_o & ready_i.
REQ-018 len_err_o  out  1  one-cycle pulse when a header len exceeds max_num_flit_p-1.

Function
REQ-019 The FSM SHALL have two states: RECV and SEND. Reset state is RECV.
REQ-020 In RECV: ready_o=1, v_o=0. In SEND: ready_o=0, v_o=1. No bypass path exists.
REQ-021 Flit counter SHALL be $clog2(max_num_flit_p) bits wide and count accepted flits of the current packet. It is 0 when a packet starts.
REQ-022 Reassembly buffer SHALL be max_num_flit_p*flit_width_p bits. Accepted flit k is written at bit offset k*flit_width_p.
REQ-023 On header acceptance (counter=0):
  - all buffer bits above flit 0 cleared;
  - len captured into a len register.
REQ-024 Completion: when the accepted flit index equals the captured len (header len for the header flit itself), the next state SHALL be SEND and the counter SHALL return to 0.
  - len=0: a header-only packet completes on the header flit.
REQ-025 Otherwise the counter SHALL increment by 1 per accepted flit and the state SHALL stay RECV.
REQ-026 Latency: v_o SHALL rise the cycle after the last flit is accepted.
REQ-027 data_o, x_o, y_o SHALL be slices of the buffer, stable while v_o=1.
REQ-028 SEND -> RECV on v_o & ready_i. The next flit can be accepted in the following cycle, so throughput is one packet per (flits+1) cycles.
REQ-029 A header with len > max_num_flit_p-1 SHALL:
  - pulse len_err_o for one cycle (the cycle after acceptance);
  - be treated as len = max_num_flit_p-1.
REQ-030 v_i while ready_o=0 SHALL have no effect. data_i is ignored when v_i=0.
REQ-031 Short packets: buffer bits beyond the received flits SHALL read 0 on data_o.

Reset
REQ-032 While reset_i=0 at a clock edge:
  - state -> RECV; counter, len register, buffer -> 0;
  - len_err_o = 0, v_o = 0;
  - ready_o = 0 during reset, 1 the cycle after release.
REQ-033 Reset asserted mid-packet or in SEND SHALL discard the partial or held packet. No v_o is produced for it.

Verification
REQ-034 3-flit packet, x=1, y=2, len=2, payload=40'hA5_1234_5678, v_i held high, ready_i=1 -> v_o high for exactly one cycle, starting the cycle after flit 2; data_o=40'hA5_1234_5678, x_o=1, y_o=2.
REQ-035 Same packet, ready_i=0 for 5 cycles -> v_o held for 6 cycles with data stable; ready_o=0 throughout; v_i flits meanwhile not consumed.
REQ-036 Header-only packet, len=0, header bits [15:6]=10'h3FF -> v_o next cycle; data_o[9:0]=10'h3FF, data_o[39:10]=0.
REQ-037 Header len=3 (max 3 flits) -> len_err_o pulses once; packet completes after 3 flits.
REQ-038 reset_i low after flit 1 of a packet, then a clean new packet -> only the new packet appears on data_o.
REQ-039 Back-to-back packets, v_i random 50%, ready_i random 50%, 1000 packets -> scoreboard matches in order; no loss or duplication.

Source files
------------

// File: rtl/bp_me_wormhole_packet_deserializer_if.sv
// Flit-in / packet-out link of the wormhole packet deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface bp_me_wormhole_packet_deserializer_if #(
    parameter int flit_width_p        = 16,
    parameter int x_cord_width_p      = 2,
    parameter int y_cord_width_p      = 2,
    parameter int max_payload_width_p = 40
);
    logic [flit_width_p-1:0]        data_i;
    logic                           v_i;
    logic                           ready_o;
    logic [max_payload_width_p-1:0] data_o;
    logic [x_cord_width_p-1:0]      x_o;
    logic [y_cord_width_p-1:0]      y_o;
    logic                           v_o;
    logic                           ready_i;
    logic                           len_err_o;

    modport slave (
        input  data_i, v_i, ready_i,
        output ready_o, data_o, x_o, y_o, v_o, len_err_o
    );

    modport master (
        output data_i, v_i, ready_i,
        input  ready_o, data_o, x_o, y_o, v_o, len_err_o
    );
endinterface

// File: rtl/bp_me_wormhole_packet_deserializer.sv
// Reassembles a header + body flit stream into one packet word, held until consumed.
// Two-state RECV/SEND machine with registered handshake outputs; no bypass path.
module bp_me_wormhole_packet_deserializer #(
    parameter int flit_width_p        = 16,
    parameter int x_cord_width_p      = 2,
    parameter int y_cord_width_p      = 2,
    parameter int len_width_p         = 2,
    parameter int max_num_flit_p      = 3,
    parameter int max_payload_width_p = 40
) (
    input  logic clk_i,
    input  logic reset_i,
    bp_me_wormhole_packet_deserializer_if.slave link
);

    localparam int cnt_w       = (max_num_flit_p > 1) ? $clog2(max_num_flit_p) : 1;
    localparam int len_off     = x_cord_width_p + y_cord_width_p;
    localparam int payload_off = len_off + len_width_p;
    localparam int buf_w       = max_num_flit_p * flit_width_p;
    localparam logic [cnt_w-1:0] last_idx = cnt_w'(max_num_flit_p - 1);

    typedef enum logic {RECV = 1'b0, SEND = 1'b1} state_e;

    state_e                                    state_r;
    logic [cnt_w-1:0]                          cnt_r;
    logic [cnt_w-1:0]                          len_r;
    logic [max_num_flit_p-1:0][flit_width_p-1:0] buf_r;
    logic                                      ready_r;
    logic                                      v_r;
    logic                                      len_err_r;

    logic                   accept;
    logic [len_width_p-1:0] hdr_len;
    logic                   hdr_len_err;
    logic [cnt_w-1:0]       hdr_len_eff;
    logic                   last_flit;

    assign accept      = link.v_i & ready_r;
    assign hdr_len     = link.data_i[len_off +: len_width_p];
    assign hdr_len_err = (int'(hdr_len) > max_num_flit_p - 1);
    // Oversized lengths are clamped so the packet still ends at the buffer limit.
    assign hdr_len_eff = hdr_len_err ? last_idx : cnt_w'(hdr_len);
    // The header flit compares against its own len; body flits against the captured one.
    assign last_flit   = (cnt_r == '0) ? (hdr_len_eff == '0) : (cnt_r == len_r);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r   <= RECV;
            cnt_r     <= '0;
            len_r     <= '0;
            buf_r     <= '0;
            ready_r   <= 1'b0;
            v_r       <= 1'b0;
            len_err_r <= 1'b0;
        end else begin
            len_err_r <= 1'b0;
            case (state_r)
                RECV: begin
                    ready_r <= 1'b1;
                    if (accept) begin
                        // A header wipes stale body flits so short packets read zero above.
                        for (int k = 0; k < max_num_flit_p; k++) begin
                            if (cnt_w'(k) == cnt_r)
                                buf_r[k] <= link.data_i;
                            else if (cnt_r == '0)
                                buf_r[k] <= '0;
                        end
                        if (cnt_r == '0) begin
                            len_r     <= hdr_len_eff;
                            len_err_r <= hdr_len_err;
                        end
                        if (last_flit) begin
                            state_r <= SEND;
                            cnt_r   <= '0;
                            ready_r <= 1'b0;
                            v_r     <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + cnt_w'(1);
                        end
                    end
                end
                SEND: begin
                    if (link.ready_i) begin
                        state_r <= RECV;
                        v_r     <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: state_r <= RECV;
            endcase
        end
    end

    logic [buf_w-1:0] buf_flat;
    logic             unused_buf;

    assign buf_flat       = buf_r;
    assign unused_buf     = ^buf_flat;
    assign link.data_o    = buf_flat[payload_off +: max_payload_width_p];
    assign link.x_o       = buf_flat[0 +: x_cord_width_p];
    assign link.y_o       = buf_flat[x_cord_width_p +: y_cord_width_p];
    assign link.ready_o   = ready_r;
    assign link.v_o       = v_r;
    assign link.len_err_o = len_err_r;

endmodule

// File: tb/tb_bp_me_wormhole_packet_deserializer.sv
// Directed table vectors, multi-cycle corner sequences and a randomized scoreboard run
// for the wormhole packet deserializer.
module tb_bp_me_wormhole_packet_deserializer;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    bp_me_wormhole_packet_deserializer_if #(
        .flit_width_p(16), .x_cord_width_p(2), .y_cord_width_p(2), .max_payload_width_p(40)
    ) link ();

    bp_me_wormhole_packet_deserializer #(
        .flit_width_p(16), .x_cord_width_p(2), .y_cord_width_p(2),
        .len_width_p(2), .max_num_flit_p(3), .max_payload_width_p(40)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .link   (link)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;

    always @(negedge clk) if (link.len_err_o === 1'b1) err_pulses++;

    typedef struct {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [1:0]  len;
        logic [39:0] pl;
        int          nf;
        logic [39:0] exp_d;
        int          exp_err;
    } vec_t;

    vec_t vecs[7];
    logic [43:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pack(input logic [1:0] x, input logic [1:0] y,
                                         input logic [1:0] len, input logic [39:0] pl);
        return {2'b00, pl, len, y, x};
    endfunction

    function automatic logic [39:0] model(input logic [1:0] x, input logic [1:0] y,
                                          input logic [1:0] len, input logic [39:0] pl);
        logic [47:0] p;
        int nf;
        p  = pack(x, y, len, pl);
        nf = (len == 2'd3) ? 3 : int'(len) + 1;
        for (int i = 0; i < 48; i++) if (i >= nf * 16) p[i] = 1'b0;
        return p[6 +: 40];
    endfunction

    task automatic send_flit(input logic [15:0] f);
        int t;
        link.data_i = f;
        link.v_i    = 1'b1;
        t = 0;
        while (link.ready_o !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) chk("flit_wait_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic send_pkt(input logic [47:0] p, input int nf);
        for (int i = 0; i < nf; i++) send_flit(p[i*16 +: 16]);
        link.v_i = 1'b0;
    endtask

    task automatic drive_rand();
        logic [1:0]  x, y, len;
        logic [39:0] pl;
        logic [47:0] pk;
        int          nf, i, cyc;
        logic        vi, acc;
        cyc = 0;
        for (int p = 0; p < 1000; p++) begin
            x = 2'($urandom); y = 2'($urandom); len = 2'($urandom);
            pl = {8'($urandom), 32'($urandom)};
            nf = (len == 2'd3) ? 3 : int'(len) + 1;
            exp_q.push_back({x, y, model(x, y, len, pl)});
            pk = pack(x, y, len, pl);
            i = 0;
            while (i < nf && cyc < 40000) begin
                vi = 1'($urandom);
                link.v_i    = vi;
                link.data_i = vi ? pk[i*16 +: 16] : 16'($urandom);
                acc = vi && link.ready_o;
                tick();
                cyc++;
                if (acc) i++;
            end
        end
        link.v_i = 1'b0;
        if (cyc >= 40000) chk("rand_drive_timeout", 64'd0, 64'd1);
    endtask

    task automatic consume_rand();
        int got, cyc;
        logic r;
        logic [43:0] e;
        got = 0; cyc = 0;
        while (got < 1000 && cyc < 45000) begin
            r = 1'($urandom);
            link.ready_i = r;
            if (link.v_o && r) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_pkt", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_pkt", {20'd0, link.x_o, link.y_o, link.data_o}, {20'd0, e});
                end
                got++;
            end
            tick();
            cyc++;
        end
        chk("rand_count", 64'(got), 64'd1000);
    endtask

    initial begin
        int e0;
        logic [47:0] p;

        vecs[0] = '{2'd1, 2'd2, 2'd2, 40'hA5_1234_5678, 3, 40'hA5_1234_5678, 0};
        vecs[1] = '{2'd3, 2'd0, 2'd0, 40'hFF_FFFF_FFFF, 1, 40'h00_0000_03FF, 0};
        vecs[2] = '{2'd0, 2'd1, 2'd1, 40'hFF_FFFF_FFFF, 2, 40'h00_03FF_FFFF, 0};
        vecs[3] = '{2'd2, 2'd3, 2'd3, 40'h12_3456_789A, 3, 40'h12_3456_789A, 1};
        vecs[4] = '{2'd0, 2'd0, 2'd2, 40'h00_0000_0000, 3, 40'h00_0000_0000, 0};
        vecs[5] = '{2'd1, 2'd1, 2'd1, 40'hC3_0F0F_1234, 2, 40'h00_030F_1234, 0};
        vecs[6] = '{2'd2, 2'd1, 2'd0, 40'h12_3456_7ABC, 1, 40'h00_0000_02BC, 0};

        reset_i = 1'b0; link.v_i = 1'b0; link.data_i = '0; link.ready_i = 1'b0;
        tick(); tick();
        chk("rst_ready", 64'(link.ready_o), 64'd0);
        chk("rst_v", 64'(link.v_o), 64'd0);
        chk("rst_len_err", 64'(link.len_err_o), 64'd0);
        chk("rst_data", 64'(link.data_o), 64'd0);
        reset_i = 1'b1;
        tick();
        chk("ready_after_release", 64'(link.ready_o), 64'd1);

        link.ready_i = 1'b1;
        foreach (vecs[n]) begin
            e0 = err_pulses;
            send_pkt(pack(vecs[n].x, vecs[n].y, vecs[n].len, vecs[n].pl), vecs[n].nf);
            chk($sformatf("vec%0d_v", n), 64'(link.v_o), 64'd1);
            chk($sformatf("vec%0d_data", n), 64'(link.data_o), 64'(vecs[n].exp_d));
            chk($sformatf("vec%0d_x", n), 64'(link.x_o), 64'(vecs[n].x));
            chk($sformatf("vec%0d_y", n), 64'(link.y_o), 64'(vecs[n].y));
            tick();
            chk($sformatf("vec%0d_v_one_cycle", n), 64'(link.v_o), 64'd0);
            chk($sformatf("vec%0d_ready_back", n), 64'(link.ready_o), 64'd1);
            chk($sformatf("vec%0d_len_err", n), 64'(err_pulses - e0), 64'(vecs[n].exp_err));
        end

        // Consumer stalls 5 cycles while the router keeps offering a flit.
        link.ready_i = 1'b0;
        e0 = err_pulses;
        send_pkt(pack(2'd1, 2'd2, 2'd2, 40'hA5_1234_5678), 3);
        link.data_i = 16'hFFFF;
        link.v_i    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stall%0d_v", c), 64'(link.v_o), 64'd1);
            chk($sformatf("stall%0d_data", c), 64'(link.data_o), 64'h00A5_1234_5678);
            chk($sformatf("stall%0d_ready", c), 64'(link.ready_o), 64'd0);
            if (c == 5) link.ready_i = 1'b1;
            tick();
        end
        link.v_i = 1'b0;
        chk("stall_release_v", 64'(link.v_o), 64'd0);
        chk("stall_release_ready", 64'(link.ready_o), 64'd1);
        send_pkt(pack(2'd3, 2'd1, 2'd2, 40'h01_2345_6789), 3);
        chk("post_stall_data", 64'(link.data_o), 64'h0001_2345_6789);
        tick();
        chk("stall_no_consume_err", 64'(err_pulses - e0), 64'd0);

        // Reset after the header of a packet discards it.
        p = pack(2'd3, 2'd3, 2'd2, 40'hDE_ADBE_EF01);
        send_flit(p[15:0]);
        link.v_i = 1'b0;
        reset_i = 1'b0;
        tick();
        chk("midrst_v", 64'(link.v_o), 64'd0);
        chk("midrst_ready", 64'(link.ready_o), 64'd0);
        reset_i = 1'b1;
        tick();
        chk("midrst_ready_back", 64'(link.ready_o), 64'd1);
        chk("midrst_no_v", 64'(link.v_o), 64'd0);
        send_pkt(pack(2'd1, 2'd0, 2'd1, 40'h00_0155_5555), 2);
        chk("midrst_new_v", 64'(link.v_o), 64'd1);
        chk("midrst_new_data", 64'(link.data_o), 64'h0000_0155_5555);
        chk("midrst_new_xy", 64'({link.x_o, link.y_o}), 64'h4);
        tick();

        // Reset while a packet is held drops it.
        link.ready_i = 1'b0;
        send_pkt(pack(2'd1, 2'd2, 2'd2, 40'hA5_1234_5678), 3);
        chk("sendrst_held", 64'(link.v_o), 64'd1);
        reset_i = 1'b0;
        tick();
        chk("sendrst_v", 64'(link.v_o), 64'd0);
        reset_i = 1'b1;
        tick();
        chk("sendrst_v_after", 64'(link.v_o), 64'd0);
        chk("sendrst_ready_after", 64'(link.ready_o), 64'd1);

        fork
            drive_rand();
            consume_rand();
        join
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
